beta_issue_ctrl: RTL and testbench

BETA_ISSUE_CTRL -- requirements
Module: beta_issue_ctrl

---
 rtl/beta_issue_ctrl_if.sv | 21 ++
 rtl/beta_issue_ctrl.sv | 128 ++++++++++++
 tb/tb_beta_issue_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/beta_issue_ctrl_if.sv
// beta_issue_ctrl_if: generator push, issue handshake and memory completion bundle
interface beta_issue_ctrl_if;
  logic        in_valid;
  logic [31:0] in_inst;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_inst;
  logic        out_ready;
  logic        mem_ack;
  logic        mem_pend;
  logic        mem_err;
  logic [7:0]  illegal_cnt;
  modport master (
    output in_valid, in_inst, out_ready, mem_ack,
    input  in_ready, out_valid, out_inst, mem_pend, mem_err, illegal_cnt
  );
  modport slave (
    input  in_valid, in_inst, out_ready, mem_ack,
    output in_ready, out_valid, out_inst, mem_pend, mem_err, illegal_cnt
  );
endinterface

// File: rtl/beta_issue_ctrl.sv
// beta_issue_ctrl: in-order issue FIFO/FSM with branch bubble and load/store wait.
// Define ISSUE_SCOREBOARD_EN to let independent REG/LIT ops issue underneath an outstanding LD.
module beta_issue_ctrl #(
  parameter int DEPTH       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input logic             CLK,
  input logic             RESET_N,
  beta_issue_ctrl_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] C_ILL = 3'd0, C_REG = 3'd1, C_LIT = 3'd2, C_BR = 3'd3, C_LD = 3'd4, C_ST = 3'd5;
  typedef enum logic [1:0] {IDLE, ISSUE, BR_BUBBLE, MEM_WAIT} state_t;
  function automatic logic [2:0] classify(input logic [5:0] op);
    return (op inside {[6'h20:6'h26], [6'h28:6'h2E]}) ? C_REG :
           (op inside {[6'h30:6'h36], [6'h38:6'h3E]}) ? C_LIT :
           (op inside {[6'h1B:6'h1D]})                ? C_BR  :
           (op == 6'h18 || op == 6'h1F)               ? C_LD  :
           (op == 6'h19)                              ? C_ST  : C_ILL;
  endfunction
  state_t        state_q;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q, rd_d, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          out_valid_q, mem_pend_q, mem_err_q;
  logic [31:0]   out_inst_q, head, nxt;
  logic [7:0]    ill_q, tmo_q;
  logic [2:0]    head_cls, cls_q;
  logic          empty, full, push, pop, hs, ill_pop, nxt_ok, mem_done, sb_ok;
  always_comb begin
    empty    = cnt_q == '0;
    full     = cnt_q == (AW+1)'(DEPTH);
    head     = mem_q[rd_q];
    nxt      = mem_q[rd_q + AW'(1)];
    head_cls = classify(head[31:26]);
    cls_q    = classify(out_inst_q[31:26]);
    nxt_ok   = cnt_q > (AW+1)'(1) && classify(nxt[31:26]) != C_ILL;
    push     = io.in_valid && !full;
    hs       = out_valid_q && io.out_ready;
    ill_pop  = state_q == IDLE && !empty && head_cls == C_ILL;
    pop      = hs || ill_pop;
    rd_d     = rd_q + AW'(pop);
    wr_d     = wr_q + AW'(push);
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    mem_done = io.mem_ack || tmo_q == 8'(MEM_TIMEOUT);
  end
`ifdef ISSUE_SCOREBOARD_EN
  logic [4:0] sb_dest_q;
  logic       sb_vld_q;
  function automatic logic src_free(input logic [4:0] src, input logic vld, input logic [4:0] dest);
    return !vld || src == 5'd31 || src != dest;
  endfunction
  assign sb_ok = !empty && (head_cls == C_REG || head_cls == C_LIT) &&
                 src_free(head[20:16], sb_vld_q, sb_dest_q) &&
                 (head_cls == C_LIT || src_free(head[15:11], sb_vld_q, sb_dest_q));
  always_ff @(posedge CLK) begin
    if (!RESET_N) sb_vld_q <= 1'b0;
    else if (state_q == ISSUE && hs && (cls_q == C_LD || cls_q == C_ST)) begin
      sb_vld_q  <= cls_q == C_LD;
      sb_dest_q <= out_inst_q[25:21];
    end
  end
`else
  assign sb_ok = 1'b0;
`endif
  always_ff @(posedge CLK) if (push) mem_q[wr_q] <= io.in_inst;
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      rd_q        <= '0;
      wr_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      mem_pend_q  <= 1'b0;
      mem_err_q   <= 1'b0;
      ill_q       <= '0;
      tmo_q       <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (ill_pop && ill_q != 8'hFF) ill_q <= ill_q + 8'd1;
      case (state_q)
        // the bubble cycle doubles as the idle decision so a branch costs exactly one dead cycle
        IDLE, BR_BUBBLE: begin
          state_q <= IDLE;
          if (!empty && head_cls != C_ILL) begin
            state_q     <= ISSUE;
            out_valid_q <= 1'b1;
            out_inst_q  <= head;
          end
        end
        ISSUE: if (hs) begin
          if (cls_q == C_REG || cls_q == C_LIT) begin
            out_valid_q <= nxt_ok;
            if (nxt_ok) out_inst_q <= nxt;
            else state_q <= IDLE;
          end else begin
            out_valid_q <= 1'b0;
            state_q     <= cls_q == C_BR ? BR_BUBBLE : MEM_WAIT;
            mem_pend_q  <= cls_q != C_BR;
            tmo_q       <= 8'd1;
          end
        end
        MEM_WAIT: if (mem_done) begin
          mem_pend_q  <= 1'b0;
          mem_err_q   <= mem_err_q || !io.mem_ack;
          out_valid_q <= out_valid_q && !hs;
          state_q     <= out_valid_q && !hs ? ISSUE : IDLE;
        end else begin
          tmo_q <= tmo_q + 8'd1;
          if (hs) out_valid_q <= 1'b0;
          else if (!out_valid_q && sb_ok) begin
            out_valid_q <= 1'b1;
            out_inst_q  <= head;
          end
        end
      endcase
    end
  end
  assign io.in_ready    = !full;
  assign io.out_valid   = out_valid_q;
  assign io.out_inst    = out_inst_q;
  assign io.mem_pend    = mem_pend_q;
  assign io.mem_err     = mem_err_q;
  assign io.illegal_cnt = ill_q;
endmodule

// File: tb/tb_beta_issue_ctrl.sv
// tb_beta_issue_ctrl: vector table for issue/branch/illegal flow plus directed memory, backpressure and reset sequences
module tb_beta_issue_ctrl;
  localparam logic [31:0] ADD  = 32'h80221800;
  localparam logic [31:0] ADD2 = 32'h84221800;
  localparam logic [31:0] BEQ  = 32'h70000000;
  localparam logic [31:0] LD5  = 32'h60A00000;
  localparam logic [31:0] ST   = 32'h64000000;
  typedef struct {
    logic        iv;
    logic [31:0] ii;
    logic        ordy;
    logic        ack;
    logic        ov;
    logic [31:0] oi;
    logic        pend;
    logic [7:0]  ill;
  } vec_t;
  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  vec_t v[16];
  logic [31:0] pushed[4];
  beta_issue_ctrl_if bus();
  beta_issue_ctrl #(.DEPTH(4), .MEM_TIMEOUT(15)) dut (.CLK(CLK), .RESET_N(RESET_N), .io(bus));
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_inst = '0;
    bus.out_ready = 1'b0;
    bus.mem_ack = 1'b0;
    RESET_N = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
  endtask
  task automatic push_one(input logic [31:0] inst);
    bus.in_valid = 1'b1;
    bus.in_inst = inst;
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic enter_mem(input logic [31:0] inst, input string nm);
    bus.out_ready = 1'b1;
    push_one(inst);
    tick();
    chk({nm, " issued"}, bus.out_valid, 1'b1);
    tick();
    chk({nm, " pend"}, bus.mem_pend, 1'b1);
  endtask
  initial begin
    int n, acc, got;
    v[0]  = '{1'b1, ADD,   1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0};
    v[1]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, ADD,   1'b0, 8'd0};
    v[2]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0};
    v[3]  = '{1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0};
    v[4]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'd1};
    v[5]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'd1};
    v[6]  = '{1'b1, BEQ,   1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'd1};
    v[7]  = '{1'b1, ADD2,  1'b1, 1'b0, 1'b1, BEQ,   1'b0, 8'd1};
    v[8]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'd1};
    v[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, ADD2,  1'b0, 8'd1};
    v[10] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'd1};
    v[11] = '{1'b1, ADD,   1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd1};
    v[12] = '{1'b1, ADD2,  1'b0, 1'b0, 1'b1, ADD,   1'b0, 8'd1};
    v[13] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, ADD,   1'b0, 8'd1};
    v[14] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, ADD2,  1'b0, 8'd1};
    v[15] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 8'd1};
    do_reset();
    chk("rst out_valid", bus.out_valid, 1'b0);
    chk("rst out_inst", bus.out_inst, 32'h0);
    chk("rst in_ready", bus.in_ready, 1'b1);
    chk("rst mem_pend", bus.mem_pend, 1'b0);
    chk("rst mem_err", bus.mem_err, 1'b0);
    chk("rst illegal_cnt", bus.illegal_cnt, 8'd0);
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = v[i].iv;
      bus.in_inst = v[i].ii;
      bus.out_ready = v[i].ordy;
      bus.mem_ack = v[i].ack;
      tick();
      chk($sformatf("vec%0d out_valid", i), bus.out_valid, v[i].ov);
      if (v[i].ov) chk($sformatf("vec%0d out_inst", i), bus.out_inst, v[i].oi);
      chk($sformatf("vec%0d in_ready", i), bus.in_ready, 1'b1);
      chk($sformatf("vec%0d mem_pend", i), bus.mem_pend, v[i].pend);
      chk($sformatf("vec%0d illegal_cnt", i), bus.illegal_cnt, v[i].ill);
    end
    do_reset();
    enter_mem(LD5, "ld_to");
    n = 0;
    while (bus.mem_pend && n < 40) begin
      n++;
      tick();
    end
    chk("ld timeout pend cycles", n, 15);
    chk("ld timeout mem_err", bus.mem_err, 1'b1);
    repeat (3) tick();
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("mem_err sticky", bus.mem_err, 1'b1);
    do_reset();
    chk("mem_err cleared by reset", bus.mem_err, 1'b0);
    enter_mem(LD5, "ld_edge");
    repeat (14) tick();
    chk("ld pend on timeout cycle", bus.mem_pend, 1'b1);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("ack on timeout cycle pend", bus.mem_pend, 1'b0);
    chk("ack on timeout cycle err", bus.mem_err, 1'b0);
    enter_mem(ST, "st");
    repeat (2) tick();
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("st ack pend", bus.mem_pend, 1'b0);
    chk("st ack err", bus.mem_err, 1'b0);
    do_reset();
    acc = 0;
    n = 0;
    bus.in_inst = 32'h0;
    bus.in_valid = 1'b1;
    while (acc < 256 && n < 600) begin
      if (bus.in_ready) acc++;
      tick();
      n++;
    end
    bus.in_valid = 1'b0;
    repeat (8) tick();
    chk("illegal accepts", acc, 256);
    chk("illegal_cnt saturates", bus.illegal_cnt, 8'd255);
    chk("illegal never issued", bus.out_valid, 1'b0);
    do_reset();
    acc = 0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.in_inst = 32'h80000000 | (32'(k + 1) << 21);
      if (bus.in_ready && acc < 4) pushed[acc] = bus.in_inst;
      if (bus.in_ready) acc++;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("backpressure accepts", acc, 4);
    chk("backpressure in_ready", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.out_valid) begin
        if (got < 4) chk($sformatf("drain order %0d", got), bus.out_inst, pushed[got]);
        got++;
      end
      tick();
    end
    chk("drain count", got, 4);
    do_reset();
    enter_mem(LD5, "rst_mem");
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    chk("rst mid-mem pend", bus.mem_pend, 1'b0);
    chk("rst mid-mem in_ready", bus.in_ready, 1'b1);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    repeat (3) tick();
    chk("late ack pend", bus.mem_pend, 1'b0);
    chk("late ack err", bus.mem_err, 1'b0);
    chk("late ack out_valid", bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;
    push_one(ADD);
    tick();
    chk("mid-issue out_valid", bus.out_valid, 1'b1);
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    chk("rst mid-issue out_valid", bus.out_valid, 1'b0);
    chk("rst mid-issue out_inst", bus.out_inst, 32'h0);
    bus.out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.out_valid) n++;
    end
    chk("no retry after reset", n, 0);
`ifdef ISSUE_SCOREBOARD_EN
    do_reset();
    bus.out_ready = 1'b1;
    push_one(LD5);
    push_one(32'hC0050000);
    push_one(32'h80060000);
    n = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.out_valid) n++;
      tick();
    end
    chk("sb dependent held", n, 0);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.out_valid) begin
        if (got == 0) chk("sb first", bus.out_inst, 32'hC0050000);
        if (got == 1) chk("sb second", bus.out_inst, 32'h80060000);
        got++;
      end
      tick();
    end
    chk("sb issue count", got, 2);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
